// File: rtl/tribus_pkg.sv
// Shared types and sizing helpers for the tri-state bus arbiter.
// Width helpers take the instance parameters so every user sizes its counters the same way.
package tribus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam int unsigned N_DEF        = 4;
    localparam int unsigned HOLD_MAX_DEF = 8;
    localparam int unsigned TURN_CYC_DEF = 1;
    localparam int unsigned MAX_N        = 32;

    function automatic int unsigned gnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Holds values 0..hmax inclusive, so the cap value itself is representable.
    function automatic int unsigned hold_w(input int unsigned hmax);
        return $clog2(hmax + 1);
    endfunction

    function automatic int unsigned turn_w(input int unsigned tc);
        return $clog2(tc + 1);
    endfunction

    function automatic logic [MAX_N-1:0] onehot_from_index(input int unsigned idx);
        return MAX_N'(1) << idx;
    endfunction

endpackage

// File: rtl/tribus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at ptr, ptr+1, ... wrapping to 0.
module rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           valid,
    output logic [IDW-1:0] idx
);

    logic [IDW-1:0] w_cand;

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_cand = IDW'((32'(ptr) + k) % N);
            if (!valid && req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/tribus_arbiter.sv
// Round-robin drive-enable generator for a shared tri-state bus: one driver at a time,
// tenures capped at HOLD_MAX cycles, TURN_CYC dead cycles between consecutive tenures.
module tribus_arbiter
    import tribus_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req,
    output logic [N-1:0]          dir,
    output logic [gnt_w(N)-1:0]   gnt_id,
    output logic                  busy,
    output logic                  preempt
);

    localparam int unsigned IDW = gnt_w(N);
    localparam int unsigned HW  = hold_w(HOLD_MAX);
    localparam int unsigned TW  = turn_w(TURN_CYC);

    state_t         r_state, w_state_nx;
    logic [N-1:0]   r_dir, w_dir_nx;
    logic [IDW-1:0] r_gnt_id, w_gnt_nx;
    logic           r_busy, w_busy_nx;
    logic           r_preempt, w_pre_nx;
    logic [HW-1:0]  r_hold, w_hold_nx;
    logic [TW-1:0]  r_turn, w_turn_nx;
    logic [IDW-1:0] r_ptr, w_ptr_nx;

    logic           w_arb;
    logic           w_pick_valid;
    logic [IDW-1:0] w_pick_idx;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_dir     <= '0;
            r_gnt_id  <= '0;
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
            r_hold    <= '0;
            r_turn    <= '0;
            r_ptr     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_dir     <= w_dir_nx;
            r_gnt_id  <= w_gnt_nx;
            r_busy    <= w_busy_nx;
            r_preempt <= w_pre_nx;
            r_hold    <= w_hold_nx;
            r_turn    <= w_turn_nx;
            r_ptr     <= w_ptr_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_dir_nx   = r_dir;
        w_gnt_nx   = r_gnt_id;
        w_busy_nx  = r_busy;
        w_pre_nx   = 1'b0;
        w_hold_nx  = r_hold;
        w_turn_nx  = r_turn;
        w_ptr_nx   = r_ptr;
        w_arb      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_arb = 1'b1;
            end
            ST_GRANT: begin
                // Release and cap share one exit; preempt marks only the cap case.
                if (!req[r_gnt_id] || (r_hold == HW'(HOLD_MAX))) begin
                    w_state_nx = ST_TURN;
                    w_dir_nx   = '0;
                    w_busy_nx  = 1'b0;
                    w_pre_nx   = req[r_gnt_id];
                    w_ptr_nx   = IDW'((32'(r_gnt_id) + 32'd1) % N);
                    w_turn_nx  = TW'(1);
                end else begin
                    w_hold_nx = r_hold + HW'(1);
                end
            end
            ST_TURN: begin
                if (r_turn == TW'(TURN_CYC)) begin
                    w_arb = 1'b1;
                end else begin
                    w_turn_nx = r_turn + TW'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_dir_nx   = '0;
                w_busy_nx  = 1'b0;
            end
        endcase

        if (w_arb) begin
            if (w_pick_valid) begin
                w_state_nx = ST_GRANT;
                w_dir_nx   = N'(onehot_from_index(32'(w_pick_idx)));
                w_gnt_nx   = w_pick_idx;
                w_busy_nx  = 1'b1;
                w_hold_nx  = HW'(1);
            end else begin
                w_state_nx = ST_IDLE;
            end
        end
    end

    assign dir     = r_dir;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign preempt = r_preempt;

endmodule
